// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer: walks the config ROM and issues one SCCB write per entry.
// Build option OV7670_CFG_NACK_RETRY_EN adds NACK re-issue with a MAX_RETRY limit and the sticky error flag.
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 250000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DELAY,
        S_SEND,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [15:0] CMD_END   = 16'hFFFF;
    localparam logic [15:0] CMD_DELAY = 16'hFFF0;
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);

    state_t           state, state_n;
    logic [7:0]       rom_addr_n;
    logic [7:0]       sccb_reg_n, sccb_data_n;
    logic [CNT_W-1:0] delay_cnt, delay_cnt_n;
    logic             done_n;
    logic             advance;

`ifdef OV7670_CFG_NACK_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_cnt, retry_cnt_n;
    logic               error_q, error_n;

    assign error = error_q;
`else
    // Without retries the NACK flag and retry limit have no effect.
    logic unused_cfg;
    assign unused_cfg = sccb_nack | (MAX_RETRY == 0);
    assign error      = 1'b0;
`endif

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_n     = state;
        rom_addr_n  = rom_addr;
        sccb_reg_n  = sccb_reg;
        sccb_data_n = sccb_data;
        delay_cnt_n = delay_cnt;
        done_n      = done;
        advance     = 1'b0;
        sccb_start  = 1'b0;
        busy        = (state != S_IDLE) && (state != S_FINISH);
`ifdef OV7670_CFG_NACK_RETRY_EN
        retry_cnt_n = retry_cnt;
        error_n     = error_q;
`endif

        case (state)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    rom_addr_n = 8'd0;
                    done_n     = 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
                    error_n     = 1'b0;
                    retry_cnt_n = '0;
`endif
                    state_n    = S_FETCH;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (rom_data == CMD_END) begin
                    done_n  = 1'b1;
                    state_n = S_FINISH;
                end else if (rom_data == CMD_DELAY) begin
                    delay_cnt_n = DELAY_LOAD;
                    state_n     = S_DELAY;
                end else begin
                    sccb_reg_n  = rom_data[15:8];
                    sccb_data_n = rom_data[7:0];
                    state_n     = S_SEND;
                end
            end
            S_DELAY: begin
                if (delay_cnt == '0) advance = 1'b1;
                else                 delay_cnt_n = delay_cnt - CNT_W'(1);
            end
            S_SEND: begin
                if (sccb_ready) begin
                    sccb_start = 1'b1;
                    state_n    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sccb_done) begin
`ifdef OV7670_CFG_NACK_RETRY_EN
                    if (!sccb_nack) begin
                        advance = 1'b1;
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt_n = retry_cnt + RETRY_W'(1);
                        state_n     = S_SEND;
                    end else begin
                        error_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = S_FINISH;
                    end
`else
                    advance = 1'b1;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Last ROM address finishes the sequence rather than wrapping to 0.
        if (advance) begin
`ifdef OV7670_CFG_NACK_RETRY_EN
            retry_cnt_n = '0;
`endif
            if (rom_addr == 8'hFF) begin
                done_n  = 1'b1;
                state_n = S_FINISH;
            end else begin
                rom_addr_n = rom_addr + 8'd1;
                state_n    = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rom_addr  <= 8'd0;
            sccb_reg  <= 8'd0;
            sccb_data <= 8'd0;
            delay_cnt <= '0;
            done      <= 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
            retry_cnt <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            rom_addr  <= rom_addr_n;
            sccb_reg  <= sccb_reg_n;
            sccb_data <= sccb_data_n;
            delay_cnt <= delay_cnt_n;
            done      <= done_n;
`ifdef OV7670_CFG_NACK_RETRY_EN
            retry_cnt <= retry_cnt_n;
            error_q   <= error_n;
`endif
        end
    end

endmodule
